// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blitter: request modes, FSM states and screen defaults.
package sprite_pkg;

    localparam logic [1:0] MODE_DRAW  = 2'b00;
    localparam logic [1:0] MODE_ERASE = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;
    localparam logic [1:0] MODE_NOP   = 2'b11;

    localparam int unsigned DEF_SCREEN_W = 320;
    localparam int unsigned DEF_SCREEN_H = 240;
    localparam int unsigned DEF_COL_W    = 3;

    typedef enum logic [2:0] {
        StIdle,
        StEAddr,
        StEWr,
        StDAddr,
        StDWr,
        StDone
    } state_t;

endpackage

// File: rtl/pixel_scan_ctr.sv
// Raster col/row counter over an SPR_W x SPR_H footprint; col advances fastest.
module pixel_scan_ctr #(
    parameter int unsigned SPR_W = 4,
    parameter int unsigned SPR_H = 4,
    localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1,
    localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == CW'(SPR_W - 1));
    assign row_end = (row == RW'(SPR_H - 1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite renderer: optional background erase of the old footprint, then a keyed, clipped
// sprite draw. Each pixel takes an address cycle and a write cycle.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W      = 4,
    parameter int unsigned SPR_H      = 4,
    parameter int unsigned SPR_COUNT  = 1,
    parameter int unsigned X_W        = 9,
    parameter int unsigned Y_W        = 8,
    parameter int unsigned COL_W      = DEF_COL_W,
    parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
    parameter int unsigned TRANSP_EN  = 1,
    parameter int unsigned TRANSP_COL = 0,
    localparam int unsigned IW = (SPR_COUNT > 1) ? $clog2(SPR_COUNT) : 1,
    localparam int unsigned AW = (SPR_COUNT * SPR_W * SPR_H > 1) ?
                                 $clog2(SPR_COUNT * SPR_W * SPR_H) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [X_W-1:0]   req_ox,
    input  logic [Y_W-1:0]   req_oy,
    input  logic [X_W-1:0]   req_nx,
    input  logic [Y_W-1:0]   req_ny,
    input  logic [IW-1:0]    req_id,
    output logic [X_W-1:0]   bg_x,
    output logic [Y_W-1:0]   bg_y,
    input  logic [COL_W-1:0] bg_col,
    output logic [AW-1:0]    spr_addr,
    input  logic [COL_W-1:0] spr_col,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_col,
    output logic             vga_plot,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    state_t         state_q, state_d;
    logic [1:0]     mode_q;
    logic [X_W-1:0] ox_q, nx_q;
    logic [Y_W-1:0] oy_q, ny_q;
    logic [IW-1:0]  id_q;

    logic           clr, adv, last;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;

    logic           erase_ph, wr, clip, transp;
    logic [X_W:0]   px;
    logic [Y_W:0]   py;
    logic [31:0]    spr_lin;

    pixel_scan_ctr #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .adv    (adv),
        .col    (col),
        .row    (row),
        .last   (last)
    );

    assign erase_ph = (state_q == StEAddr) || (state_q == StEWr);
    assign wr       = (state_q == StEWr) || (state_q == StDWr);

    // One extra bit keeps the carry so wrapped coordinates are clipped, not folded back.
    assign px = {1'b0, (erase_ph ? ox_q : nx_q)} + (X_W + 1)'(col);
    assign py = {1'b0, (erase_ph ? oy_q : ny_q)} + (Y_W + 1)'(row);

    assign clip   = px[X_W] || (32'(px) >= SCREEN_W) || py[Y_W] || (32'(py) >= SCREEN_H);
    assign transp = (TRANSP_EN != 0) && (spr_col == COL_W'(TRANSP_COL));

    assign bg_x     = px[X_W-1:0];
    assign bg_y     = py[Y_W-1:0];
    assign spr_lin  = 32'(id_q) * (SPR_W * SPR_H) + 32'(row) * SPR_W + 32'(col);
    assign spr_addr = spr_lin[AW-1:0];

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    clr = 1'b1;
                    case (req_mode)
                        MODE_DRAW: state_d = StDAddr;
                        MODE_NOP:  state_d = StDone;
                        default:   state_d = StEAddr;
                    endcase
                end
            end
            StEAddr: state_d = StEWr;
            StEWr: begin
                adv = 1'b1;
                if (last) begin
                    clr     = 1'b1;
                    state_d = (mode_q == MODE_BOTH) ? StDAddr : StDone;
                end else begin
                    state_d = StEAddr;
                end
            end
            StDAddr: state_d = StDWr;
            StDWr: begin
                adv     = 1'b1;
                state_d = last ? StDone : StDAddr;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            mode_q   <= MODE_DRAW;
            ox_q     <= '0;
            oy_q     <= '0;
            nx_q     <= '0;
            ny_q     <= '0;
            id_q     <= '0;
            vga_x    <= '0;
            vga_y    <= '0;
            vga_col  <= '0;
            vga_plot <= 1'b0;
        end else begin
            state_q  <= state_d;
            vga_plot <= 1'b0;
            if (state_q == StIdle && req_valid) begin
                mode_q <= req_mode;
                ox_q   <= req_ox;
                oy_q   <= req_oy;
                nx_q   <= req_nx;
                ny_q   <= req_ny;
                id_q   <= req_id;
            end
            if (wr) begin
                vga_x    <= px[X_W-1:0];
                vga_y    <= py[Y_W-1:0];
                vga_col  <= erase_ph ? bg_col : spr_col;
                vga_plot <= !clip && (erase_ph || !transp);
            end
        end
    end

endmodule
